// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight and a fixed DATA_WIDTH-cycle CALC phase.
// Multiply and divide share one 2*DATA_WIDTH accumulator that works on operand magnitudes.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [2:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [W-1:0]            a_mag_q, b_mag_q;
    logic                    a_neg_q, b_neg_q, div_zero_q, overflow_q;
    logic [2*W-1:0]          acc_q, acc_step;

    logic                    accept, last_iter;
    logic                    signed_a, signed_b, a_neg, b_neg;
    logic [W-1:0]            a_mag, b_mag;
    logic [W:0]              mul_sum, div_shift, div_diff;
    logic [2*W-1:0]          prod;
    logic [W-1:0]            quot, rem, result;

    assign accept    = (state_q == IDLE) && start_i;
    assign last_iter = (state_q == CALC) && (cnt_q == CNT_W'(W - 1));
    assign busy_o    = (state_q != IDLE);

    assign signed_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign signed_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg    = signed_a & rs1_data_i[W-1];
    assign b_neg    = signed_b & rs2_data_i[W-1];
    assign a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    assign b_mag    = b_neg ? -rs2_data_i : rs2_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply: shift-add with the multiplier in the low half. Divide: restoring, remainder high, quotient low.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        if (op_q[2]) begin
            if (!div_diff[W]) acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            else              acc_step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        prod   = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
        quot   = (a_neg_q ^ b_neg_q) ? -acc_step[W-1:0] : acc_step[W-1:0];
        rem    = a_neg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              result = quot;
            OP_REM, OP_REMU:              result = rem;
        endcase
        // Special cases were flagged at accept; op_q[1] separates remainder ops from quotient ops.
        if (div_zero_q)      result = op_q[1] ? (a_neg_q ? -a_mag_q : a_mag_q) : '1;
        else if (overflow_q) result = op_q[1] ? '0 : MOST_NEG;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= '0;
            done_o     <= 1'b0;
            rd_data_o  <= '0;
            rd_addr_o  <= '0;
        end else begin
            done_o <= last_iter;
            if (accept) begin
                cnt_q      <= '0;
                op_q       <= op_i;
                addr_q     <= rd_addr_i;
                a_mag_q    <= a_mag;
                b_mag_q    <= b_mag;
                a_neg_q    <= a_neg;
                b_neg_q    <= b_neg;
                div_zero_q <= op_i[2] && (rs2_data_i == '0);
                overflow_q <= ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                              (rs1_data_i == MOST_NEG) && (rs2_data_i == '1);
                acc_q      <= {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_step;
            end
            if (last_iter) begin
                rd_data_o <= result;
                rd_addr_o <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors go into a scoreboard queue, and a
// monitor compares them against each done pulse. Timing, hold-start and mid-op reset are also covered.
module tb_muldiv_unit;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [2:0]    op_i;
    logic [DW-1:0] rs1_data_i;
    logic [DW-1:0] rs2_data_i;
    logic [AW-1:0] rd_addr_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_o;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    muldiv_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            checkOutput("done_has_expectation", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("rd_data", rd_data_o, e.data);
                checkOutput("rd_addr", {27'b0, rd_addr_o}, {27'b0, e.addr});
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 34 with the unit idle again.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expected);
        int   done_k;
        int   busy_cnt;
        exp_t e;
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        e.data = expected;
        e.addr = rd;
        sb_q.push_back(e);
        done_k   = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (k == 1) start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_k = k;
                break;
            end
        end
        checkOutput({name, "_done_cycle"}, done_k, 32'd33);
        checkOutput({name, "_busy_cycles"}, busy_cnt, 32'd33);
        @(negedge clk_i);
        checkOutput({name, "_idle_after"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   done_cnt;
        int   done_k;
        exp_t e;

        rst_i      = 1'b1;
        start_i    = 1'b0;
        op_i       = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rd_addr_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset_busy",    {31'b0, busy_o}, 32'd0);
        checkOutput("reset_done",    {31'b0, done_o}, 32'd0);
        checkOutput("reset_rd_data", rd_data_o, 32'd0);
        checkOutput("reset_rd_addr", {27'b0, rd_addr_o}, 32'd0);

        applyStimulus("mul_neg",      3'd0, 32'd7,         32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB);
        applyStimulus("mulh_min",     3'd1, 32'h80000000,  32'h80000000, 5'd2,  32'h40000000);
        applyStimulus("mulhsu_ones",  3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF);
        applyStimulus("mulhu_ones",   3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE);
        applyStimulus("mulh_neg1x2",  3'd1, 32'hFFFFFFFF,  32'd2,        5'd14, 32'hFFFFFFFF);
        applyStimulus("mul_wrap",     3'd0, 32'h00010000,  32'h00010000, 5'd15, 32'h00000000);
        applyStimulus("mul_x0",       3'd0, 32'h00012345,  32'h00000010, 5'd0,  32'h00123450);
        applyStimulus("div_neg",      3'd4, 32'hFFFFFFF9,  32'd2,        5'd5,  32'hFFFFFFFD);
        applyStimulus("rem_neg",      3'd6, 32'hFFFFFFF9,  32'd2,        5'd6,  32'hFFFFFFFF);
        applyStimulus("divu",         3'd5, 32'd100,       32'd7,        5'd7,  32'd14);
        applyStimulus("remu",         3'd7, 32'd100,       32'd7,        5'd8,  32'd2);
        applyStimulus("div_negdiv",   3'd4, 32'd20,        32'hFFFFFFFA, 5'd16, 32'hFFFFFFFD);
        applyStimulus("rem_negdiv",   3'd6, 32'd20,        32'hFFFFFFFA, 5'd17, 32'd2);
        applyStimulus("divu_zero",    3'd5, 32'd5,         32'd0,        5'd9,  32'hFFFFFFFF);
        applyStimulus("div_zero",     3'd4, 32'd5,         32'd0,        5'd18, 32'hFFFFFFFF);
        applyStimulus("rem_zero",     3'd6, 32'd5,         32'd0,        5'd10, 32'd5);
        applyStimulus("rem_negzero",  3'd6, 32'hFFFFFFFB,  32'd0,        5'd19, 32'hFFFFFFFB);
        applyStimulus("remu_zero",    3'd7, 32'hFFFFFFFB,  32'd0,        5'd22, 32'hFFFFFFFB);
        applyStimulus("div_ovf",      3'd4, 32'h80000000,  32'hFFFFFFFF, 5'd11, 32'h80000000);
        applyStimulus("rem_ovf",      3'd6, 32'h80000000,  32'hFFFFFFFF, 5'd12, 32'd0);

        // start_i held high for the whole op while rd_addr_i wanders.
        op_i       = 3'd5;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        rd_addr_i  = 5'd20;
        start_i    = 1'b1;
        e.data = 32'd14;
        e.addr = 5'd20;
        sb_q.push_back(e);
        done_cnt = 0;
        done_k   = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk_i);
            rd_addr_i = (k == 34) ? 5'd21 : 5'($urandom_range(0, 31));
            if (done_o) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 34) begin
                checkOutput("hold_idle_c34", {31'b0, busy_o}, 32'd0);
                e.data = 32'd14;
                e.addr = 5'd21;
                sb_q.push_back(e);
            end
        end
        checkOutput("hold_done_count", done_cnt, 32'd1);
        checkOutput("hold_done_cycle", done_k, 32'd33);
        @(negedge clk_i);
        checkOutput("hold_reaccept_c35", {31'b0, busy_o}, 32'd1);
        start_i = 1'b0;
        done_k  = 0;
        for (int k = 36; k <= 80; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_k = k;
                break;
            end
        end
        checkOutput("hold_second_done_cycle", done_k, 32'd67);
        @(negedge clk_i);

        // Reset pulsed during cycle 10 of an op: no write-back may ever appear for it.
        op_i       = 3'd0;
        rs1_data_i = 32'd7;
        rs2_data_i = 32'd3;
        rd_addr_i  = 5'd13;
        start_i    = 1'b1;
        done_cnt   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (k == 1) start_i = 1'b0;
            if (k == 10) rst_i = 1'b1;
            if (done_o) done_cnt++;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("midreset_busy",    {31'b0, busy_o}, 32'd0);
        checkOutput("midreset_done",    {31'b0, done_o}, 32'd0);
        checkOutput("midreset_rd_data", rd_data_o, 32'd0);
        checkOutput("midreset_rd_addr", {27'b0, rd_addr_o}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
        end
        checkOutput("midreset_no_done", done_cnt, 32'd0);
        applyStimulus("post_reset_mul", 3'd0, 32'd7, 32'd3, 5'd13, 32'd21);

        repeat (2) @(negedge clk_i);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
